gpio_ctrl: RTL

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gpio_ctrl.sv
// GPIO controller: data/direction registers, synchronised inputs, edge-detect
// interrupts with W1C status, and a latency-1 register read port.
module gpio_ctrl #(
    parameter int N           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [7:0]   addr,
    input  logic [31:0]  wdata,
    output logic [31:0]  rdata,
    output logic         rvalid,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] gpio_out,
    output logic [N-1:0] gpio_oe,
    output logic         irq
);

    localparam logic [7:0] A_DATA  = 8'h00;
    localparam logic [7:0] A_DIR   = 8'h04;
    localparam logic [7:0] A_IN    = 8'h08;
    localparam logic [7:0] A_SET   = 8'h0C;
    localparam logic [7:0] A_CLR   = 8'h10;
    localparam logic [7:0] A_TGL   = 8'h14;
    localparam logic [7:0] A_IE    = 8'h18;
    localparam logic [7:0] A_IRISE = 8'h1C;
    localparam logic [7:0] A_IFALL = 8'h20;
    localparam logic [7:0] A_ISTAT = 8'h24;

    logic [N-1:0] data_q,  data_d;
    logic [N-1:0] dir_q,   dir_d;
    logic [N-1:0] ie_q,    ie_d;
    logic [N-1:0] irise_q, irise_d;
    logic [N-1:0] ifall_q, ifall_d;
    logic [N-1:0] istat_q, istat_d;
    logic [N-1:0] prev_q,  prev_d;
    logic [N-1:0] out_q,   out_d;
    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] sync_d [SYNC_STAGES];
    logic [31:0]  rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;
    logic         irq_q,    irq_d;

    logic [N-1:0] wbits, sync_in, evt, w1c, rd_bits;

    assign wbits   = wdata[N-1:0];
    assign sync_in = sync_q[SYNC_STAGES-1];
    assign evt     = (sync_in & ~prev_q & irise_q) | (~sync_in & prev_q & ifall_q);

    always_comb begin
        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        ie_d    = ie_q;
        irise_d = irise_q;
        ifall_d = ifall_q;
        w1c     = '0;
        if (wr_en) begin
            // Unaligned and unmapped addresses match no item and fall through.
            case (addr)
                A_DATA:  data_d  = wbits;
                A_DIR:   dir_d   = wbits;
                A_SET:   data_d  = data_q | wbits;
                A_CLR:   data_d  = data_q & ~wbits;
                A_TGL:   data_d  = data_q ^ wbits;
                A_IE:    ie_d    = wbits;
                A_IRISE: irise_d = wbits;
                A_IFALL: ifall_d = wbits;
                A_ISTAT: w1c     = wbits;
                default: ;
            endcase
        end
        // New events are ORed in after the clear, so a same-cycle event wins.
        istat_d = (istat_q & ~w1c) | evt;
        prev_d  = sync_in;
        out_d   = data_d & dir_d;
        irq_d   = |(istat_q & ie_q);
    end

    always_comb begin
        rd_bits = '0;
        case (addr)
            A_DATA:  rd_bits = data_q;
            A_DIR:   rd_bits = dir_q;
            A_IN:    rd_bits = sync_in;
            A_IE:    rd_bits = ie_q;
            A_IRISE: rd_bits = irise_q;
            A_IFALL: rd_bits = ifall_q;
            A_ISTAT: rd_bits = istat_q;
            default: ;
        endcase
        rdata_d = '0;
        if (rd_en) begin
            rdata_d[N-1:0] = rd_bits;
        end
        rvalid_d = rd_en;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            irise_q  <= '0;
            ifall_q  <= '0;
            istat_q  <= '0;
            prev_q   <= '0;
            out_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            data_q   <= data_d;
            dir_q    <= dir_d;
            ie_q     <= ie_d;
            irise_q  <= irise_d;
            ifall_q  <= ifall_d;
            istat_q  <= istat_d;
            prev_q   <= prev_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            irq_q    <= irq_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule
